// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package pipe_pkg;

   // Instruction and register-index geometry
   localparam int unsigned REG_W            = 5;
   localparam int unsigned IR_W             = 32;
   localparam int unsigned RS1_LSB          = 15;
   localparam int unsigned RS2_LSB          = 20;

   // Default number of MEM_WAIT cycles tolerated before mem_timeout
   localparam int unsigned WAIT_MAX_DEFAULT = 255;

   // Width of the optional stalled-cycle counter
   localparam int unsigned STALL_CNT_W      = 32;

   // Controller FSM states
   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

   // Pipeline register enables and bubble-insert controls
   typedef struct packed {
      logic pc_we;
      logic ifid_we;
      logic idex_we;
      logic exmem_we;
      logic ifid_flush;
      logic idex_flush;
      logic memwb_flush;
   } ctrl_t;

   // Everything advances, no bubbles
   localparam ctrl_t CTRL_NORMAL = '{
      pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1, exmem_we: 1'b1,
      ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b0};

   // Reset: hold every register and bubble every stage
   localparam ctrl_t CTRL_RESET = '{
      pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0, exmem_we: 1'b0,
      ifid_flush: 1'b1, idex_flush: 1'b1, memwb_flush: 1'b1};

   // Data memory not ready: freeze front of pipe, bubble into WB
   localparam ctrl_t CTRL_MEM_STALL = '{
      pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0, exmem_we: 1'b0,
      ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b1};

   // Taken branch in EX: squash the two younger wrong-path instructions
   localparam ctrl_t CTRL_BRANCH = '{
      pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1, exmem_we: 1'b1,
      ifid_flush: 1'b1, idex_flush: 1'b1, memwb_flush: 1'b0};

   // Load-use: hold PC and IF/ID, inject one bubble into EX
   localparam ctrl_t CTRL_LOAD_USE = '{
      pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b1, exmem_we: 1'b1,
      ifid_flush: 1'b0, idex_flush: 1'b1, memwb_flush: 1'b0};

   // Wait counter width: wide enough for max_val, never below 8 bits
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = $clog2(max_val + 1);
      return (w > 8) ? w : 8;
   endfunction

endpackage : pipe_pkg

// File: rtl/pipe_ctrl_load_use_det.sv
// Load-use hazard detector: a load in EX whose destination feeds the
// instruction in ID. Writes to x0 are discarded, so rd=0 never stalls.
module load_use_det
   import pipe_pkg::*;
(
   input  logic             memread_EX,
   input  logic [REG_W-1:0] rd_EX,
   input  logic [IR_W-1:0]  ir_ID,
   output logic             load_use
);

   logic [REG_W-1:0] rs1;
   logic [REG_W-1:0] rs2;
   logic             unused_ir_bits;

   assign rs1 = ir_ID[RS1_LSB +: REG_W];
   assign rs2 = ir_ID[RS2_LSB +: REG_W];

   // Opcode/funct/rd fields of the ID instruction play no part in the compare
   assign unused_ir_bits = ^{ir_ID[IR_W-1:RS2_LSB+REG_W], ir_ID[RS1_LSB-1:0]};

   // Register-index match against either source operand
   always_comb begin
      load_use = 1'b0;
      if (memread_EX && (rd_EX != '0)) begin
         load_use = (rd_EX == rs1) || (rd_EX == rs2);
      end
   end

endmodule : load_use_det

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard and stall controller.
// Resolves data-memory stalls, taken branches and load-use hazards into
// per-stage register enables and bubble controls. Enables and flushes are
// combinational so they act in the same cycle as the hazard; mem_timeout
// is a sticky registered error.
// Optional feature: define PIPE_STALL_CNT_EN to add the stall_cnt output.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   memread_EX,
   input  logic [REG_W-1:0]       rd_EX,
   input  logic [IR_W-1:0]        ir_ID,
   input  logic                   branch_taken_EX,
   input  logic                   dmem_req_MEM,
   input  logic                   dmem_ready,
   output logic                   pc_we,
   output logic                   ifid_we,
   output logic                   idex_we,
   output logic                   exmem_we,
   output logic                   ifid_flush,
   output logic                   idex_flush,
   output logic                   memwb_flush,
   output logic                   mem_timeout
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   localparam int unsigned CNT_W = cnt_width(WAIT_MAX);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] wait_cnt_q;
   logic [CNT_W-1:0] wait_cnt_d;
   logic             mem_timeout_q;
   logic             mem_timeout_d;
   logic             load_use;
   logic             mem_stall;
   ctrl_t            ctrl;

   // Load-use compare between EX destination and ID sources
   load_use_det u_load_use_det (
      .memread_EX (memread_EX),
      .rd_EX      (rd_EX),
      .ir_ID      (ir_ID),
      .load_use   (load_use)
   );

   // Memory not completing this cycle stalls in either state
   assign mem_stall = dmem_req_MEM && !dmem_ready;

   // Next state, wait counter, timeout flag and prioritised stage controls
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = '0;
      mem_timeout_d = mem_timeout_q;
      ctrl          = CTRL_NORMAL;

      case (state_q)
         ST_RUN: begin
            if (mem_stall) begin
               state_d = ST_MEM_WAIT;
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_stall) begin
               state_d = ST_RUN;
            end else begin
               wait_cnt_d = (wait_cnt_q == CNT_W'(WAIT_MAX)) ? wait_cnt_q
                                                             : wait_cnt_q + CNT_W'(1);
               if (wait_cnt_d == CNT_W'(WAIT_MAX)) begin
                  mem_timeout_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      // A branch held across a memory wait is only seen once, on release,
      // because the mem stall masks it until then.
      if (rst) begin
         ctrl = CTRL_RESET;
      end else if (mem_stall) begin
         ctrl = CTRL_MEM_STALL;
      end else if (branch_taken_EX) begin
         ctrl = CTRL_BRANCH;
      end else if (load_use) begin
         ctrl = CTRL_LOAD_USE;
      end
   end

   // State, wait counter and sticky timeout registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign pc_we       = ctrl.pc_we;
   assign ifid_we     = ctrl.ifid_we;
   assign idex_we     = ctrl.idex_we;
   assign exmem_we    = ctrl.exmem_we;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_flush  = ctrl.idex_flush;
   assign memwb_flush = ctrl.memwb_flush;
   assign mem_timeout = mem_timeout_q;

`ifdef PIPE_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q;

   // Count every non-reset cycle in which the PC is held; wraps naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (!ctrl.pc_we) begin
         stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule : pipe_ctrl

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: memread_EX  in  1  ID/EX.MemRead; rd_EX  in  5  ID/EX.RegisterRd; ir_ID  in  32  IF/ID instruction (rs1=[19:15], rs2=[24:20]).
REQ-003 SHALL have ports: branch_taken_EX  in  1  branch/jump resolved taken in EX; dmem_req_MEM  in  1  load/store in MEM; dmem_ready  in  1  data memory completes this cycle.
REQ-004 SHALL have outputs, all 1 bit: pc_we, ifid_we, idex_we, exmem_we (register enables); ifid_flush, idex_flush, memwb_flush (insert bubble); mem_timeout (sticky error).
REQ-005 SHALL have parameter: WAIT_MAX, default 255, max MEM_WAIT cycles before mem_timeout.
REQ-006 SHALL, with PIPE_STALL_CNT_EN defined, add output stall_cnt  out  32  count of stalled cycles.

Function
REQ-007 SHALL implement a two-state FSM: RUN, MEM_WAIT.
REQ-008 load_use SHALL be memread_EX && rd_EX!=0 && (rd_EX==rs1 || rd_EX==rs2); x0 never stalls.
REQ-009 mem_stall SHALL be dmem_req_MEM && !dmem_ready, in either state.
REQ-010 Priority per cycle SHALL be mem_stall > branch_taken_EX > load_use > normal.
REQ-011 Normal: all *_we=1, all flushes=0.
REQ-012 mem_stall: pc_we=ifid_we=idex_we=exmem_we=0, memwb_flush=1, other flushes=0; asserted combinationally in the same cycle; next state MEM_WAIT.
REQ-013 branch_taken_EX (no mem_stall): all *_we=1, ifid_flush=1, idex_flush=1; any coincident load_use is ignored (wrong path).
REQ-014 load_use (no mem_stall, no branch): pc_we=0, ifid_we=0, idex_flush=1, idex_we=exmem_we=1; exactly one bubble, as load advances to MEM next cycle.
REQ-015 MEM_WAIT with dmem_ready=1: outputs follow RUN rules (REQ-010..014) the same cycle; next state RUN.
REQ-016 A branch_taken_EX held during MEM_WAIT SHALL be acted on in the release cycle, never lost or doubled.
REQ-017 wait_cnt (8+ bits, sized for WAIT_MAX) SHALL clear on RUN entry, increment each MEM_WAIT cycle, saturate at WAIT_MAX.
REQ-018 mem_timeout SHALL set the cycle after wait_cnt reaches WAIT_MAX and stay 1 until rst; freeze behaviour unchanged.

Reset
REQ-019 On rst=1 at clk edge: state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0.
REQ-020 While rst=1: all *_we=0, all flushes=1, regardless of other inputs.
REQ-021 rst mid-MEM_WAIT SHALL abort the wait; first post-reset cycle is RUN.

Configuration
REQ-022 Macro PIPE_STALL_CNT_EN: defined -> stall_cnt increments (wrapping at 2^32) every non-reset cycle with pc_we=0; undefined -> port and counter absent, all other behaviour identical.

Structure
REQ-023 Shared package pipe_pkg SHALL hold the FSM state enum, reg-index field positions (RS1_LSB=15, RS2_LSB=20) and default WAIT_MAX.
REQ-024 Load-use compare SHALL be a sub-module load_use_det (memread_EX, rd_EX, ir_ID -> load_use).

Verification
REQ-025 memread_EX=1, rd_EX=5, ir_ID rs1=5 -> one cycle pc_we=0, ifid_we=0, idex_flush=1; next cycle all we=1.
REQ-026 memread_EX=1, rd_EX=0, rs1=0 -> no stall, all we=1.
REQ-027 load_use and branch_taken_EX same cycle -> ifid_flush=idex_flush=1, pc_we=1.
REQ-028 dmem_req_MEM=1, dmem_ready=0 for 3 cycles then 1 -> 3 cycles all we=0, memwb_flush=1; 4th cycle normal; state back to RUN.
REQ-029 WAIT_MAX=4, dmem_ready held 0 -> mem_timeout=1 from the 6th stall cycle on, cleared only by rst; stall_cnt (macro on) equals stalled cycles.
